// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  localparam int unsigned BSA_DEFAULT_WIDTH = 8;

  // Bit-position counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int unsigned bsa_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder composed of two half-add stages with ORed carries.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_sum;
  logic ha1_carry;

  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  assign ha1_sum   = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  assign sum   = ha1_sum;
  assign carry = ha0_carry | ha1_carry;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-add cell reused for WIDTH cycles per operation.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = BSA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CntW    = bsa_cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  bsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_shift;

  full_adder_bit u_full_adder_bit (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  assign sum_shift = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = ADD;
        end
      end

      ADD: begin
        sum_sh_d = sum_shift;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Result registers load only here so they hold their value outside DONE.
          sum_d   = sum_shift;
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] sum1;
  logic       cout1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({in_ready, in_ready1} !== 2'b00) begin
      $display("FAIL reset_in_ready: got %b want 00", {in_ready, in_ready1});
      miscompares++;
    end
    vectors++;
    if ({out_valid, sum, cout, out_valid1, sum1, cout1} !== 13'b0) begin
      $display("FAIL reset_outputs: got v=%b s=%h c=%b v1=%b s1=%b c1=%b want all 0",
               out_valid, sum, cout, out_valid1, sum1, cout1);
      miscompares++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready, in_ready1} !== 2'b11) begin
      $display("FAIL reset_release_in_ready: got %b want 11", {in_ready, in_ready1});
      miscompares++;
    end
  endtask

  task automatic test_basic();
    int n;
    start_op(8'h0F, 8'h01, 1'b0);
    wait_out(n);
    vectors++;
    if (n !== 8) begin
      $display("FAIL basic_latency: got %0d edges want 8", n);
      miscompares++;
    end
    vectors++;
    if ({cout, sum} !== 9'h010) begin
      $display("FAIL basic_result: got cout=%b sum=%h want cout=0 sum=10", cout, sum);
      miscompares++;
    end
    step();
    vectors++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 8'h10}) begin
      $display("FAIL basic_handshake: got v=%b rdy=%b sum=%h want v=0 rdy=1 sum=10",
               out_valid, in_ready, sum);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    int n;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_out(n);
    vectors++;
    if ({cout, sum} !== 9'h100) begin
      $display("FAIL wrap_ff_01: got cout=%b sum=%h want cout=1 sum=00", cout, sum);
      miscompares++;
    end
    step();
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_out(n);
    vectors++;
    if ({cout, sum} !== 9'h1FF) begin
      $display("FAIL wrap_ff_ff_1: got cout=%b sum=%h want cout=1 sum=ff", cout, sum);
      miscompares++;
    end
    step();
  endtask

  task automatic test_carry_in();
    int n;
    start_op(8'h00, 8'h00, 1'b1);
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    vectors++;
    if (in_ready !== 1'b0) begin
      $display("FAIL carry_in_busy_ready: got %b want 0", in_ready);
      miscompares++;
    end
    step();
    in_valid = 1'b0;
    wait_out(n);
    vectors++;
    if ({cout, sum} !== 9'h001) begin
      $display("FAIL carry_in_result: got cout=%b sum=%h want cout=0 sum=01", cout, sum);
      miscompares++;
    end
    step();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    start_op(8'h3C, 8'h4B, 1'b1);
    wait_out(n);
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h88}) begin
        $display("FAIL stall_hold[%0d]: got v=%b rdy=%b c=%b s=%h want v=1 rdy=0 c=0 s=88",
                 i, out_valid, in_ready, cout, sum);
        miscompares++;
      end
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      miscompares++;
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      $display("FAIL stall_next_accept: got rdy=%b want 0", in_ready);
      miscompares++;
    end
    wait_out(n);
    vectors++;
    if ({n, cout, sum} !== {32'd8, 1'b0, 8'h46}) begin
      $display("FAIL stall_next_result: got n=%0d c=%b s=%h want n=8 c=0 s=46", n, cout, sum);
      miscompares++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    int  n;
    logic seen;
    start_op(8'h55, 8'hAA, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      $display("FAIL rst_add_ready: got %b want 0", in_ready);
      miscompares++;
    end
    step();
    vectors++;
    if ({out_valid, cout, sum} !== 10'b0) begin
      $display("FAIL rst_add_outputs: got v=%b c=%b s=%h want all 0", out_valid, cout, sum);
      miscompares++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rst_add_release: got rdy=%b want 1", in_ready);
      miscompares++;
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL rst_add_stale: got out_valid pulse=%b want 0", seen);
      miscompares++;
    end

    out_ready = 1'b0;
    start_op(8'h12, 8'h34, 1'b0);
    wait_out(n);
    rst = 1'b1;
    step();
    vectors++;
    if ({out_valid, cout, sum} !== 10'b0) begin
      $display("FAIL rst_done_outputs: got v=%b c=%b s=%h want all 0", out_valid, cout, sum);
      miscompares++;
    end
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if ({seen, in_ready} !== 2'b01) begin
      $display("FAIL rst_done_stale: got pulse=%b rdy=%b want pulse=0 rdy=1", seen, in_ready);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] exp8;
    logic [1:0] exp1;
    int acc8 = 0, acc1 = 0, done8 = 0, done1 = 0;
    int last8 = -1, last1 = -1, cyc = 0;
    out_ready = 1'b1;
    out_ready1 = 1'b1;
    while ((done8 < N || done1 < N) && cyc < 40000) begin
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      in_valid = (acc8 < N);
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      cin1 = 1'($urandom);
      in_valid1 = (acc1 < N);
      if (in_valid && in_ready) begin
        q8.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
        if (last8 >= 0) begin
          vectors++;
          if (cyc - last8 !== 10) begin
            $display("FAIL b2b_spacing8: got %0d cycles want 10", cyc - last8);
            miscompares++;
          end
        end
        last8 = cyc;
        acc8++;
      end
      if (in_valid1 && in_ready1) begin
        q1.push_back({1'b0, a1} + {1'b0, b1} + 2'(cin1));
        if (last1 >= 0) begin
          vectors++;
          if (cyc - last1 !== 3) begin
            $display("FAIL b2b_spacing1: got %0d cycles want 3", cyc - last1);
            miscompares++;
          end
        end
        last1 = cyc;
        acc1++;
      end
      step();
      cyc++;
      if (out_valid === 1'b1) begin
        exp8 = (q8.size() > 0) ? q8.pop_front() : 9'bx;
        vectors++;
        if ({cout, sum} !== exp8) begin
          $display("FAIL b2b_result8[%0d]: got %h want %h", done8, {cout, sum}, exp8);
          miscompares++;
        end
        done8++;
      end
      if (out_valid1 === 1'b1) begin
        exp1 = (q1.size() > 0) ? q1.pop_front() : 2'bx;
        vectors++;
        if ({cout1, sum1} !== exp1) begin
          $display("FAIL b2b_result1[%0d]: got %b want %b", done1, {cout1, sum1}, exp1);
          miscompares++;
        end
        done1++;
      end
    end
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    vectors++;
    if (done8 < N || done1 < N) begin
      $display("FAIL b2b_timeout: got %0d/%0d results want %0d/%0d", done8, done1, N, N);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_carry_in();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
LSB-first bit-serial adder that consumes two WIDTH-bit operands and a carry-in through a valid/ready handshake. It produces a registered WIDTH-bit sum and carry-out after WIDTH add cycles. One single-bit full-add cell is reused every cycle, trading latency for area. It sits directly downstream of the single-bit half-add primitives; the full-add cell is built from two half-add stages plus an OR.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and cin valid.
in_ready  output  1  block can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum/cout valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  a + b + cin, low WIDTH bits.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE; out_valid=0; sum=0; cout=0.
  - Internal shift registers, carry flop and counter are all 0.
  - in_ready=0 while rst is high.
- State machine: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on a rising edge with in_valid&&in_ready: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0; go to ADD.
  - a, b and cin are sampled only at the accept edge.
- ADD:
  - in_ready=0; in_valid is ignored.
  - Each edge: s=a_sh[0]^b_sh[0]^carry; c=majority(a_sh[0],b_sh[0],carry).
  - Each edge: sum_sh<={s,sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge, go to DONE.
  - Exactly WIDTH edges are spent in ADD.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry. All are registered and held stable until the handshake.
  - On out_valid&&out_ready, go to IDLE at that edge. out_valid drops the next cycle; sum and cout keep their last values.
  - out_ready is ignored outside DONE.
- Latency: out_valid asserts WIDTH edges after the accept edge.
- Throughput: one operation per WIDTH+2 cycles minimum, since there is no accept in the same cycle as the result handshake.
- Arithmetic:
  - Result equals (a+b+cin) mod 2^WIDTH; cout=bit WIDTH of the full sum.
  - cnt width = max(1,$clog2(WIDTH)).
  - WIDTH=1: ADD lasts one cycle.
- Boundary conditions:
  - All-ones + 1 wraps: sum=0, cout=1.
  - Reset mid-ADD or mid-DONE aborts the operation with no out_valid pulse; the block returns to reset values.
  - in_valid held high continuously: the next operation is accepted on the first IDLE cycle.
  - out_ready held low: the block stalls in DONE indefinitely with outputs stable.

Decomposition:
- Package bit_serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE=2'd0, ADD=2'd1, DONE=2'd2} bsa_state_t.
  - localparam BSA_DEFAULT_WIDTH=8.
- Sub-module full_adder_bit: combinational, inputs a, b, cin; outputs sum, carry. Built as two half-add stages with the carries ORed. Instantiated once in the ADD datapath.

Test Plan:
- Basic add: WIDTH=8, a=8'h0F, b=8'h01, cin=0 -> out_valid exactly 8 edges after accept; sum=8'h10, cout=0.
- Wrap-around: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Carry-in only: a=0, b=0, cin=1 -> sum=8'h01, cout=0. After accept, change a/b/cin mid-ADD -> result unchanged.
- Back-pressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid, sum and cout stable and in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1, new operation accepted.
- Reset mid-operation: accept a=8'h55, b=8'hAA, assert rst on the 3rd ADD cycle -> next cycle out_valid=0, sum=0, cout=0, and in_ready=1 after rst deasserts. No stale result ever appears.
- Back-to-back plus random: in_valid and out_ready tied high, 1000 random operations at WIDTH=8 and WIDTH=1 -> every result matches the reference model; spacing is WIDTH+2 cycles.
